cache_arbiter: RTL
==================

Name: cache_arbiter

Overview:
- Shares the single fully associative cache port between two requesters: port 0 (instruction fetch) and port 1 (accumulator data load/store).
- Round-robin arbitration; latches the winning request and drives the cache control lines.
- Waits out the variable cache latency: 1 cycle on a hit, multi-cycle on a miss with RAM writeback/fill.
- Returns data with a one-cycle ack; keeps hit/miss statistics and a timeout error flag.

Parameters:
D_WIDTH, 8, data width
A_WIDTH, 8, address width
TIMEOUT, 15, max cycles in WAIT before abort (must be >= 12)

Ports:
clk  in  1  system clock, all logic on posedge
clr  in  1  reset; synchronous, active-high
req0  in  1  port 0 request, level, held until ack0
rw0  in  1  port 0: 0 read, 1 write
addr0  in  A_WIDTH  port 0 address
wdata0  in  D_WIDTH  port 0 write data
ack0  out  1  port 0 completion pulse
rdata0  out  D_WIDTH  port 0 read data
req1, rw1, addr1, wdata1, ack1, rdata1  same as port 0, for port 1
c_enab  out  1  cache enable
c_rw  out  1  cache read/write
c_addr  out  A_WIDTH  cache address
c_wdata  out  D_WIDTH  cache write data
c_rdata  in  D_WIDTH  cache read data
c_done  in  1  cache access complete, one-cycle pulse
c_hit  in  1  valid with c_done; 1 = access hit
grant  out  1  index of the port currently being served
busy  out  1  high in every state except IDLE
err  out  1  sticky timeout flag
hit_cnt  out  8  saturating hit counter
miss_cnt  out  8  saturating miss counter

Behaviour:
- All outputs are registered.
- Reset (clr=1 at posedge, any state, including mid-access):
  - state=IDLE; c_enab, c_rw, ack0, ack1, busy, err, grant = 0.
  - c_addr, c_wdata, rdata0, rdata1, hit_cnt, miss_cnt = 0; timeout counter = 0.
  - last_grant = 1, so port 0 wins the first tie.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If only reqN is high, select N.
  - If both are high, select the port other than last_grant.
  - On a selection: latch rwN, addrN, wdataN into c_rw, c_addr, c_wdata; set grant=N, last_grant=N, busy=1; go to ISSUE.
  - Input changes after this capture are ignored until ack.
- ISSUE: c_enab=1; timeout counter cleared; go to WAIT.
- WAIT:
  - c_enab held at 1; the counter increments each cycle.
  - On c_done: if the access was a read, capture c_rdata into rdata[grant]. Increment hit_cnt if c_hit, else miss_cnt, saturating at 255. Drop c_enab; go to RESP.
  - If the counter reaches TIMEOUT without c_done: set err=1, drop c_enab, leave rdata unchanged, count nothing; go to RESP.
  - c_done arriving in the same cycle the counter reaches TIMEOUT counts as done; err stays 0.
- RESP:
  - ack[grant]=1 for exactly one cycle; go to IDLE.
  - rdataN holds its value until the next read completes on that port.
- Requester rule: deassert reqN, or present a new request, in the cycle after ackN. A reqN still high when the arbiter is back in IDLE is treated as a new request.
- Minimum turnaround: request sampled in IDLE at cycle T, ISSUE at T+1, first possible c_done at T+2, ack at T+3. Back-to-back requests lose 1 IDLE cycle.
- c_done in IDLE, ISSUE or RESP: ignored. Counters are not touched.
- err clears only on clr.
- Write accesses leave rdata unchanged.

Test Plan:
- Port 0 read only, addr0=8'h05, cache returns c_rdata=8'hA5, c_hit=1 two cycles after ISSUE -> ack0 pulse at T+3, rdata0=8'hA5, hit_cnt=1, grant=0, ack1 never high.
- req0 and req1 both high from reset, both held after ack -> service order 0,1,0,1; each ack is one cycle; at most one ack per cycle.
- Port 1 write, addr1=8'h03, wdata1=8'h3C, c_done with c_hit=0 after 11 cycles -> c_rw=1, c_addr=8'h03, c_wdata=8'h3C held throughout WAIT; ack1 at the end; miss_cnt=1; rdata1 unchanged.
- No c_done ever asserted -> c_enab drops after TIMEOUT=15 WAIT cycles, err=1, ack pulses once, counters unchanged; the next request still completes normally and err stays 1.
- clr=1 asserted in mid-WAIT -> next cycle state IDLE, c_enab=0, busy=0, counters=0, err=0; a late c_done is ignored; with both reqs high, port 0 is granted first.
- 256 hits -> hit_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// Requester-side and cache-side signal bundle for cache_arbiter.
// slave: arbiter view; master: requesters plus cache model view.
interface cache_arbiter_if #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8
);
  logic               req0;
  logic               rw0;
  logic [A_WIDTH-1:0] addr0;
  logic [D_WIDTH-1:0] wdata0;
  logic               ack0;
  logic [D_WIDTH-1:0] rdata0;
  logic               req1;
  logic               rw1;
  logic [A_WIDTH-1:0] addr1;
  logic [D_WIDTH-1:0] wdata1;
  logic               ack1;
  logic [D_WIDTH-1:0] rdata1;
  logic               c_enab;
  logic               c_rw;
  logic [A_WIDTH-1:0] c_addr;
  logic [D_WIDTH-1:0] c_wdata;
  logic [D_WIDTH-1:0] c_rdata;
  logic               c_done;
  logic               c_hit;
  logic               grant;
  logic               busy;
  logic               err;
  logic [7:0]         hit_cnt;
  logic [7:0]         miss_cnt;

  modport slave (
    input  req0, rw0, addr0, wdata0,
    input  req1, rw1, addr1, wdata1,
    input  c_rdata, c_done, c_hit,
    output ack0, rdata0, ack1, rdata1,
    output c_enab, c_rw, c_addr, c_wdata,
    output grant, busy, err,
    output hit_cnt, miss_cnt
  );

  modport master (
    output req0, rw0, addr0, wdata0,
    output req1, rw1, addr1, wdata1,
    output c_rdata, c_done, c_hit,
    input  ack0, rdata0, ack1, rdata1,
    input  c_enab, c_rw, c_addr, c_wdata,
    input  grant, busy, err,
    input  hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cache port between fetch (0) and
// data (1) requesters; waits out cache latency, acks, keeps stats.
module cache_arbiter #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8,
  parameter int TIMEOUT = 15
) (
  input logic           clk,
  input logic           clr,
  cache_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic               w_take;
  logic               w_sel;
  logic               w_done;
  logic               w_tmo;

  logic [CW-1:0]      r_cnt;
  logic               r_last;
  logic               r_grant;
  logic               r_busy;
  logic               r_err;
  logic               r_enab;
  logic               r_rw;
  logic [A_WIDTH-1:0] r_addr;
  logic [D_WIDTH-1:0] r_wdata;
  logic [D_WIDTH-1:0] r_rdata0;
  logic [D_WIDTH-1:0] r_rdata1;
  logic               r_ack0;
  logic               r_ack1;
  logic [7:0]         r_hit;
  logic [7:0]         r_miss;

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    w_sel  = 1'b0;
    w_done = 1'b0;
    w_tmo  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // on a tie the port not served last wins
        if (bus.req0 && bus.req1) begin
          w_take = 1'b1;
          w_sel  = ~r_last;
        end else if (bus.req0) begin
          w_take = 1'b1;
          w_sel  = 1'b0;
        end else if (bus.req1) begin
          w_take = 1'b1;
          w_sel  = 1'b1;
        end
        if (w_take) w_next = ISSUE;
      end
      ISSUE: w_next = WAIT;
      WAIT: begin
        if (bus.c_done) begin
          w_done = 1'b1;
          w_next = RESP;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_tmo  = 1'b1;
          w_next = RESP;
        end
      end
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt    <= '0;
      r_last   <= 1'b1;
      r_grant  <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_enab   <= 1'b0;
      r_rw     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_hit    <= '0;
      r_miss   <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_take) begin
            r_grant <= w_sel;
            r_last  <= w_sel;
            r_busy  <= 1'b1;
            r_rw    <= w_sel ? bus.rw1    : bus.rw0;
            r_addr  <= w_sel ? bus.addr1  : bus.addr0;
            r_wdata <= w_sel ? bus.wdata1 : bus.wdata0;
          end
        end
        ISSUE: begin
          r_enab <= 1'b1;
          r_cnt  <= '0;
        end
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_done) begin
            r_enab <= 1'b0;
            if (!r_rw) begin
              if (r_grant) r_rdata1 <= bus.c_rdata;
              else         r_rdata0 <= bus.c_rdata;
            end
            if (bus.c_hit) begin
              if (r_hit != 8'hFF) r_hit <= r_hit + 8'd1;
            end else begin
              if (r_miss != 8'hFF) r_miss <= r_miss + 8'd1;
            end
          end else if (w_tmo) begin
            r_err  <= 1'b1;
            r_enab <= 1'b0;
          end
        end
        RESP: begin
          r_ack0 <= ~r_grant;
          r_ack1 <= r_grant;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ack0     = r_ack0;
  assign bus.ack1     = r_ack1;
  assign bus.rdata0   = r_rdata0;
  assign bus.rdata1   = r_rdata1;
  assign bus.c_enab   = r_enab;
  assign bus.c_rw     = r_rw;
  assign bus.c_addr   = r_addr;
  assign bus.c_wdata  = r_wdata;
  assign bus.grant    = r_grant;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;
  assign bus.hit_cnt  = r_hit;
  assign bus.miss_cnt = r_miss;

endmodule
